regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Arbitrates the register file's single write port between the pipeline writeback stage and a long-latency result source such as a multi-cycle multiply/divide unit or a load-miss return. Writeback requests take priority. Long-latency results queue in a small FIFO and drain into idle write-port cycles. The block drives the RegisterFile write port (reg_wr, reg_wr_addr, reg_wr_data) through registered outputs, and it reports pending-write hazards to the hazard unit.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 4, pending-result entries; power of two, ≥2
- STARVE_LIMIT, 4, consecutive lost arbitrations before a forced FIFO grant (used only with the fairness macro)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- wb_wr  in  1  writeback stage requests a write this cycle
- wb_addr  in  ADDR_W  writeback destination register
- wb_data  in  DATA_W  writeback data
- wb_stall  out  1  writeback must hold its request; this cycle's request is not taken
- mc_valid  in  1  long-latency unit presents a result
- mc_addr  in  ADDR_W  result destination register
- mc_data  in  DATA_W  result data
- mc_ready  out  1  FIFO can accept; a transfer occurs when mc_valid && mc_ready at the edge
- reg_wr  out  1  RegisterFile write enable (registered)
- reg_wr_addr  out  ADDR_W  RegisterFile write address (registered)
- reg_wr_data  out  DATA_W  RegisterFile write data (registered)
- chk_addr1, chk_addr2  in  ADDR_W  source registers of the instruction in decode
- chk_busy1, chk_busy2  out  1  the corresponding source has a write pending
- pend_count  out  log2(FIFO_DEPTH)+1  number of occupied FIFO entries

## Operation
- FIFO: circular buffer with rd_ptr, wr_ptr, and count. mc_ready = (count < FIFO_DEPTH). There is no pass-through when full, even if a dequeue occurs in the same cycle.
- Register 0 filter:
  - A writeback with wb_addr==0 is treated as no request.
  - An accepted mc transfer with mc_addr==0 is consumed (the handshake completes) but is not enqueued.
- Arbitration, evaluated each cycle:
  1. If wb_wr && wb_addr!=0 && !wb_stall: grant WB.
  2. Else if count>0: grant the FIFO head and dequeue it.
  3. Else: no write.
- The winner's address and data load into reg_wr_addr and reg_wr_data, and reg_wr<=1. With no winner, reg_wr<=0 and addr/data hold their values.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- chk_busyN is asserted when chk_addrN!=0 and either:
  - any valid FIFO entry has that address, or
  - reg_wr && reg_wr_addr==chk_addrN.
  
  chk_busyN is combinational from registered state only.
- Results for the same address leave the FIFO in arrival order.

## Timing
- Reset (synchronous, wins over all other activity in that cycle):
  - reg_wr=0, reg_wr_addr=0, reg_wr_data=0
  - count=0, both pointers=0, starve counter=0
  - wb_stall=0, mc_ready=1, pend_count=0, chk_busy1/2=0
  - FIFO contents are discarded.
- Latency:
  - A WB request granted at edge N writes the RegisterFile at edge N+1. reg_wr is high during cycle N→N+1.
  - An mc result accepted at edge N is enqueued. It wins arbitration no earlier than edge N+1 and reaches the RegisterFile at edge N+2 at the earliest.
- Back-to-back WB requests in consecutive cycles are all granted, and the FIFO drains only in WB-idle cycles.
- The FIFO can be full while WB is continuously busy. In that case mc_ready=0, and the mc unit holds mc_valid, mc_addr, and mc_data stable.

## Configuration
- REGFILE_ARB_FAIRNESS_EN defined:
  - starve_cnt increments each cycle that count>0 and WB wins.
  - starve_cnt clears when the FIFO wins or count==0.
  - wb_stall = (starve_cnt==STARVE_LIMIT), decoded from the register.
  - In a wb_stall cycle, the FIFO head is granted and starve_cnt clears. The writeback stage holds its request, which is granted on the next cycle.
- REGFILE_ARB_FAIRNESS_EN undefined:
  - Strict WB priority.
  - wb_stall is tied to 0 and no starve counter exists.

## Test plan
- Reset held for 3 cycles with mc_valid=1 → reg_wr=0, pend_count=0, mc_ready=1 throughout, and nothing enqueued after reset deasserts.
- WB write 20 to r7 → reg_wr=1, reg_wr_addr=7, reg_wr_data=20 one cycle later. A RegisterFile read of r7 returns 20 afterwards.
- wb_wr held high for 10 cycles while 5 mc results to r8..r12 are offered:
  - 4 are accepted, then mc_ready=0 and pend_count=4.
  - Without the macro: no mc writes occur until WB idles, then r8..r11 drain in order, followed by r12.
- With REGFILE_ARB_FAIRNESS_EN and STARVE_LIMIT=4, WB continuous with the FIFO non-empty → wb_stall pulses for one cycle every 5th cycle, and the FIFO head is written in that cycle.
- mc result to r0 and WB write to r0 → mc handshake completes, pend_count stays 0, reg_wr never asserts.
- mc result 99 to r5 enqueued while WB is busy, with chk_addr1=5 → chk_busy1=1 until the cycle after the r5 write, then 0. chk_addr2=6 gives chk_busy2=0 throughout.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the register file's single write port between the
//                writeback stage (priority) and a long-latency result source.
//                Long-latency results wait in a small circular FIFO and
//                drain into cycles where writeback is idle. The write port
//                outputs are registered. Pending writes are reported to the
//                hazard unit through chk_busy1/chk_busy2.
//                Optional macro REGFILE_ARB_FAIRNESS_EN adds a starvation
//                counter that forces a FIFO grant (and stalls writeback for
//                one cycle) after STARVE_LIMIT consecutive lost arbitrations.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    // writeback stage
    input  logic                          wb_wr,
    input  logic [ADDR_W-1:0]             wb_addr,
    input  logic [DATA_W-1:0]             wb_data,
    output logic                          wb_stall,
    // long-latency result source
    input  logic                          mc_valid,
    input  logic [ADDR_W-1:0]             mc_addr,
    input  logic [DATA_W-1:0]             mc_data,
    output logic                          mc_ready,
    // register file write port
    output logic                          reg_wr,
    output logic [ADDR_W-1:0]             reg_wr_addr,
    output logic [DATA_W-1:0]             reg_wr_data,
    // hazard checks
    input  logic [ADDR_W-1:0]             chk_addr1,
    input  logic [ADDR_W-1:0]             chk_addr2,
    output logic                          chk_busy1,
    output logic                          chk_busy2,
    output logic [$clog2(FIFO_DEPTH):0]   pend_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = FIFO_DEPTH[c_CNT_W-1:0];

    // Parameter sanity: pointer wrap relies on a power-of-two depth.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("regfile_write_arbiter: FIFO_DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("regfile_write_arbiter: STARVE_LIMIT must be >= 1");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // ------------------------------------------------------------------------
    // Arbitration decode
    // ------------------------------------------------------------------------
    logic w_fifo_nonempty;
    logic w_wb_req;
    logic w_grant_wb;
    logic w_deq;
    logic w_mc_xfer;
    logic w_enq;

    assign w_fifo_nonempty = (r_count != '0);
    // A write to r0 is architecturally a no-op, so it never competes.
    assign w_wb_req        = wb_wr && (wb_addr != '0);
    assign w_grant_wb      = w_wb_req && !wb_stall;
    assign w_deq           = !w_grant_wb && w_fifo_nonempty;
    // No pass-through when full: readiness depends only on the stored count.
    assign mc_ready        = (r_count < c_DEPTH);
    assign w_mc_xfer       = mc_valid && mc_ready;
    // r0 results complete the handshake but are dropped.
    assign w_enq           = w_mc_xfer && (mc_addr != '0);

    assign pend_count      = r_count;

`ifdef REGFILE_ARB_FAIRNESS_EN
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = STARVE_LIMIT[c_STARVE_W-1:0];
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = 1;

    logic [c_STARVE_W-1:0] r_starve_cnt;

    // Count consecutive cycles where a waiting FIFO head loses to writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant_wb && w_fifo_nonempty) begin
            r_starve_cnt <= r_starve_cnt + c_STARVE_ONE;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Decoded from the register so the stall is glitch-free and early.
    assign wb_stall = (r_starve_cnt == c_STARVE_LIM);
`else
    assign wb_stall = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FIFO storage (contents need no reset; validity comes from the count)
    // ------------------------------------------------------------------------
    // Capture an accepted non-r0 result at the write pointer.
    always_ff @(posedge clk) begin
        if (!reset && w_enq) begin
            r_fifo_addr[r_wr_ptr] <= mc_addr;
            r_fifo_data[r_wr_ptr] <= mc_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous enq/deq keeps count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------------
    // Load the winner; with no winner only the enable drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_wr      <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
        end else if (w_grant_wb) begin
            reg_wr      <= 1'b1;
            reg_wr_addr <= wb_addr;
            reg_wr_data <= wb_data;
        end else if (w_deq) begin
            reg_wr      <= 1'b1;
            reg_wr_addr <= r_fifo_addr[r_rd_ptr];
            reg_wr_data <= r_fifo_data[r_rd_ptr];
        end else begin
            reg_wr      <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Hazard reporting
    // ------------------------------------------------------------------------
    logic [FIFO_DEPTH-1:0] w_hit1;
    logic [FIFO_DEPTH-1:0] w_hit2;

    // A slot is live when its distance from the read pointer is below count;
    // this also covers the full case where every slot is live.
    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_slot
        logic [c_PTR_W-1:0] w_off;
        logic               w_live;
        assign w_off     = c_PTR_W'(g) - r_rd_ptr;
        assign w_live    = ({1'b0, w_off} < r_count);
        assign w_hit1[g] = w_live && (r_fifo_addr[g] == chk_addr1);
        assign w_hit2[g] = w_live && (r_fifo_addr[g] == chk_addr2);
    end

    // A source is busy while queued or while its write is on the port.
    always_comb begin
        chk_busy1 = (chk_addr1 != '0) &&
                    ((|w_hit1) || (reg_wr && (reg_wr_addr == chk_addr1)));
        chk_busy2 = (chk_addr2 != '0) &&
                    ((|w_hit2) || (reg_wr && (reg_wr_addr == chk_addr2)));
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Self-checking bench for regfile_write_arbiter. A queue-based
//                reference model predicts the write port, occupancy and
//                hazard outputs; scenario tasks compare the DUT against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_wr;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_stall;
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              chk_busy1;
    logic              chk_busy2;
    logic [2:0]        pend_count;

    regfile_write_arbiter #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_wr      (wb_wr),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_stall   (wb_stall),
        .mc_valid   (mc_valid),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .reg_wr     (reg_wr),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .chk_busy1  (chk_busy1),
        .chk_busy2  (chk_busy2),
        .pend_count (pend_count)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT's write port.
    logic [DATA_W-1:0] tb_rf [32];
    always @(posedge clk) begin
        if (reg_wr) tb_rf[reg_wr_addr] <= reg_wr_data;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              m_q[$];
    logic              m_reg_wr   = 1'b0;
    logic [ADDR_W-1:0] m_addr     = '0;
    logic [DATA_W-1:0] m_data     = '0;
    int                m_starve   = 0;
    logic              m_accepted = 1'b0;

    function automatic logic m_stall();
`ifdef REGFILE_ARB_FAIRNESS_EN
        return (m_starve == STARVE_LIMIT);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
        foreach (m_q[i]) if (m_q[i].addr == a) return 1'b1;
        return m_reg_wr && (m_addr == a);
    endfunction

    // Advance the model by one clock using the current inputs, then step the
    // clock and settle 1 ns past the edge.
    task automatic tick();
        int   n_before;
        logic wb_win;
        ent_t e;
        n_before   = m_q.size();
        m_accepted = !reset && mc_valid && (n_before < FIFO_DEPTH);
        if (reset) begin
            m_q.delete();
            m_reg_wr = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_starve = 0;
        end else begin
            wb_win = wb_wr && (wb_addr != 0) && !m_stall();
            if (wb_win) begin
                m_reg_wr = 1'b1;
                m_addr   = wb_addr;
                m_data   = wb_data;
            end else if (n_before > 0) begin
                e        = m_q.pop_front();
                m_reg_wr = 1'b1;
                m_addr   = e.addr;
                m_data   = e.data;
            end else begin
                m_reg_wr = 1'b0;
            end
            if (m_accepted && mc_addr != 0) begin
                e.addr = mc_addr;
                e.data = mc_data;
                m_q.push_back(e);
            end
            m_starve = (wb_win && n_before > 0) ? m_starve + 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; mc_valid = 1'b1; mc_addr = 5'd3; mc_data = 32'hdead;
        wb_wr = 1'b1; wb_addr = 5'd4; wb_data = 32'd1;
        chk_addr1 = 5'd3; chk_addr2 = 5'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL reset_reg_wr c%0d: got %b want 0", i, reg_wr); end
            n_checks++; if (pend_count !== 3'd0) begin n_fail++; $display("FAIL reset_pend c%0d: got %0d want 0", i, pend_count); end
            n_checks++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mc_ready c%0d: got %b want 1", i, mc_ready); end
            n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_wb_stall c%0d: got %b want 0", i, wb_stall); end
            n_checks++; if ({chk_busy1, chk_busy2} !== 2'b00) begin n_fail++; $display("FAIL reset_busy c%0d: got %b want 00", i, {chk_busy1, chk_busy2}); end
        end
        n_checks++; if (reg_wr_addr !== 5'd0 || reg_wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_port: got %0d/%0d want 0/0", reg_wr_addr, reg_wr_data); end
        reset = 1'b0; mc_valid = 1'b0; wb_wr = 1'b0;
        tick();
        n_checks++; if (pend_count !== 3'd0) begin n_fail++; $display("FAIL post_reset_pend: got %0d want 0", pend_count); end
        n_checks++; if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL post_reset_reg_wr: got %b want 0", reg_wr); end
    endtask

    task automatic test_wb_write();
        wb_wr = 1'b1; wb_addr = 5'd7; wb_data = 32'd20;
        tick();
        n_checks++; if (reg_wr !== 1'b1 || reg_wr_addr !== 5'd7 || reg_wr_data !== 32'd20) begin
            n_fail++; $display("FAIL wb_write: got %b/%0d/%0d want 1/7/20", reg_wr, reg_wr_addr, reg_wr_data);
        end
        wb_wr = 1'b0;
        tick();
        n_checks++; if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL wb_idle: got %b want 0", reg_wr); end
        n_checks++; if (tb_rf[7] !== 32'd20) begin n_fail++; $display("FAIL rf_r7: got %0d want 20", tb_rf[7]); end
    endtask

    task automatic test_fifo_full();
        int next_mc = 8;
        int obs[$];
        mc_valid = 1'b1; mc_addr = 5'd8; mc_data = 32'd1008;
        for (int i = 0; i < 30; i++) begin
            wb_wr = (i < 10) || (m_stall() && wb_wr);
            if (!(m_stall() && wb_wr && i <= 10)) begin
                wb_addr = 5'($urandom_range(13, 31));
                wb_data = $urandom;
            end
            if (i >= 10 && wb_wr && !m_stall()) wb_wr = 1'b0;
            n_checks++; if (mc_ready !== (m_q.size() < FIFO_DEPTH)) begin n_fail++; $display("FAIL full_mc_ready c%0d: got %b want %b", i, mc_ready, m_q.size() < FIFO_DEPTH); end
            n_checks++; if (pend_count !== m_q.size()) begin n_fail++; $display("FAIL full_pend c%0d: got %0d want %0d", i, pend_count, m_q.size()); end
`ifndef REGFILE_ARB_FAIRNESS_EN
            if (i == 9) begin
                n_checks++; if (pend_count !== 3'd4 || mc_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got pend=%0d ready=%b want 4/0", pend_count, mc_ready); end
            end
`endif
            tick();
            if (m_accepted) begin
                next_mc++;
                mc_valid = (next_mc <= 12);
                mc_addr  = 5'(next_mc);
                mc_data  = 32'(1000 + next_mc);
            end
            n_checks++; if (reg_wr !== m_reg_wr || reg_wr_addr !== m_addr || reg_wr_data !== m_data) begin
                n_fail++; $display("FAIL full_port c%0d: got %b/%0d/%0h want %b/%0d/%0h", i, reg_wr, reg_wr_addr, reg_wr_data, m_reg_wr, m_addr, m_data);
            end
            if (reg_wr && reg_wr_addr >= 8 && reg_wr_addr <= 12) obs.push_back(int'(reg_wr_addr));
        end
        n_checks++; if (obs.size() != 5) begin n_fail++; $display("FAIL drain_count: got %0d want 5", obs.size()); end
        foreach (obs[i]) begin
            n_checks++; if (obs[i] != 8 + i) begin n_fail++; $display("FAIL drain_order #%0d: got r%0d want r%0d", i, obs[i], 8 + i); end
        end
        n_checks++; if (tb_rf[12] !== 32'd1012) begin n_fail++; $display("FAIL rf_r12: got %0d want 1012", tb_rf[12]); end
    endtask

    task automatic test_fairness();
        int n_stall = 0;
        wb_wr = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (!m_stall()) begin
                wb_addr = 5'($urandom_range(1, 7));
                wb_data = $urandom;
            end
            if (!mc_valid || m_accepted) begin
                mc_valid = 1'b1;
                mc_addr  = 5'($urandom_range(16, 20));
                mc_data  = $urandom;
            end
            n_checks++; if (wb_stall !== m_stall()) begin n_fail++; $display("FAIL fair_stall c%0d: got %b want %b", i, wb_stall, m_stall()); end
            if (wb_stall === 1'b1) n_stall++;
            tick();
            n_checks++; if (reg_wr !== m_reg_wr || reg_wr_addr !== m_addr || reg_wr_data !== m_data) begin
                n_fail++; $display("FAIL fair_port c%0d: got %b/%0d/%0h want %b/%0d/%0h", i, reg_wr, reg_wr_addr, reg_wr_data, m_reg_wr, m_addr, m_data);
            end
        end
`ifdef REGFILE_ARB_FAIRNESS_EN
        n_checks++; if (n_stall != 4) begin n_fail++; $display("FAIL fair_pulses: got %0d want 4", n_stall); end
`else
        n_checks++; if (n_stall != 0) begin n_fail++; $display("FAIL fair_pulses: got %0d want 0", n_stall); end
`endif
        wb_wr = 1'b0; mc_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (pend_count !== 3'd0 || reg_wr !== 1'b0) begin n_fail++; $display("FAIL fair_drain: got pend=%0d wr=%b want 0/0", pend_count, reg_wr); end
    endtask

    task automatic test_r0();
        mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'd77;
        wb_wr = 1'b1; wb_addr = 5'd0; wb_data = 32'd55;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready c%0d: got %b want 1", i, mc_ready); end
            tick();
            n_checks++; if (pend_count !== 3'd0) begin n_fail++; $display("FAIL r0_pend c%0d: got %0d want 0", i, pend_count); end
            n_checks++; if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL r0_reg_wr c%0d: got %b want 0", i, reg_wr); end
        end
        mc_valid = 1'b0; wb_wr = 1'b0;
    endtask

    task automatic test_busy();
        chk_addr1 = 5'd5; chk_addr2 = 5'd6;
        mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'd99;
        for (int i = 0; i < 12; i++) begin
            wb_wr = (i < 6) || (m_stall() && wb_wr);
            if (!m_stall()) begin
                wb_addr = 5'($urandom_range(1, 4));
                wb_data = $urandom;
            end
            tick();
            if (m_accepted) mc_valid = 1'b0;
            n_checks++; if (chk_busy1 !== exp_busy(5'd5)) begin n_fail++; $display("FAIL busy1 c%0d: got %b want %b", i, chk_busy1, exp_busy(5'd5)); end
            n_checks++; if (chk_busy2 !== 1'b0) begin n_fail++; $display("FAIL busy2 c%0d: got %b want 0", i, chk_busy2); end
        end
        n_checks++; if (tb_rf[5] !== 32'd99) begin n_fail++; $display("FAIL rf_r5: got %0d want 99", tb_rf[5]); end
        wb_wr = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!(m_stall() && wb_wr)) begin
                wb_wr   = ($urandom_range(0, 9) < 6);
                wb_addr = 5'($urandom_range(0, 7));
                wb_data = $urandom;
            end
            if (!(mc_valid && !m_accepted)) begin
                mc_valid = ($urandom_range(0, 9) < 4);
                mc_addr  = 5'($urandom_range(0, 7));
                mc_data  = $urandom;
            end
            chk_addr1 = 5'($urandom_range(0, 7));
            chk_addr2 = 5'($urandom_range(0, 7));
            #1;
            n_checks++; if (wb_stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", i, wb_stall, m_stall()); end
            n_checks++; if (mc_ready !== (m_q.size() < FIFO_DEPTH)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", i, mc_ready, m_q.size() < FIFO_DEPTH); end
            n_checks++; if (pend_count !== m_q.size()) begin n_fail++; $display("FAIL rnd_pend c%0d: got %0d want %0d", i, pend_count, m_q.size()); end
            n_checks++; if (chk_busy1 !== exp_busy(chk_addr1) || chk_busy2 !== exp_busy(chk_addr2)) begin
                n_fail++; $display("FAIL rnd_busy c%0d: got %b%b want %b%b", i, chk_busy1, chk_busy2, exp_busy(chk_addr1), exp_busy(chk_addr2));
            end
            tick();
            n_checks++; if (reg_wr !== m_reg_wr || reg_wr_addr !== m_addr || reg_wr_data !== m_data) begin
                n_fail++; $display("FAIL rnd_port c%0d: got %b/%0d/%0h want %b/%0d/%0h", i, reg_wr, reg_wr_addr, reg_wr_data, m_reg_wr, m_addr, m_data);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wb_wr = 1'b0; wb_addr = '0; wb_data = '0;
        mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
        chk_addr1 = '0; chk_addr2 = '0;
        test_reset();
        test_wb_write();
        test_fifo_full();
        test_fairness();
        test_r0();
        test_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
